serv_timer: RTL

// - RISC-V machine timer on the SERV data bus; drives serv_top i_timer_irq.
// - Holds 64-bit mtime and mtimecmp, accessed as four 32-bit Wishbone words.
// - Asserts o_timer_irq while mtime >= mtimecmp (unsigned).

---
 rtl/serv_timer.sv | 67 ++++++
 1 files changed

// File: rtl/serv_timer.sv
// serv_timer: RISC-V machine timer with 64-bit mtime/mtimecmp exposed as four Wishbone words
module serv_timer #(
    parameter int          DIV     = 1,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);
    logic [15:0] presc;
    logic [63:0] mtime, mtimecmp, mtime_nxt, cmp_nxt;
    logic [31:0] hi_shadow, rdt_sel;
    logic        tick, commit, wr, rd;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i+:8] = sel[i] ? dat[8*i+:8] : old[8*i+:8];
        return m;
    endfunction

    always_comb begin
        tick   = presc == 16'(DIV - 1);
        commit = i_wb_cyc & ~o_wb_ack;
        wr     = commit & i_wb_we;
        rd     = commit & ~i_wb_we;
        // a write to either mtime word replaces the whole tick, so no carry crosses words
        mtime_nxt = (wr && i_wb_adr == 2'd0) ? {mtime[63:32], merge(mtime[31:0], i_wb_dat, i_wb_sel)} :
                    (wr && i_wb_adr == 2'd1) ? {merge(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]} :
                    mtime + 64'(tick);
        cmp_nxt   = (wr && i_wb_adr == 2'd2) ? {mtimecmp[63:32], merge(mtimecmp[31:0], i_wb_dat, i_wb_sel)} :
                    (wr && i_wb_adr == 2'd3) ? {merge(mtimecmp[63:32], i_wb_dat, i_wb_sel), mtimecmp[31:0]} :
                    mtimecmp;
        rdt_sel   = (i_wb_adr == 2'd0) ? mtime[31:0] :
                    (i_wb_adr == 2'd1) ? hi_shadow :
                    (i_wb_adr == 2'd2) ? mtimecmp[31:0] : mtimecmp[63:32];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc       <= '0;
            mtime       <= '0;
            mtimecmp    <= CMP_RST;
            hi_shadow   <= '0;
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= '0;
            o_timer_irq <= 1'b0;
        end else begin
            presc       <= tick ? 16'd0 : presc + 16'd1;
            mtime       <= mtime_nxt;
            mtimecmp    <= cmp_nxt;
            o_wb_ack    <= commit;
            o_timer_irq <= mtime >= mtimecmp;
            if (rd)
                o_wb_rdt <= rdt_sel;
            if (rd && i_wb_adr == 2'd0)
                hi_shadow <= mtime[63:32];
        end
    end
endmodule
